// File: rtl/gray_step_arbiter.sv
// Round-robin arbiter that shares one external 3-bit gray counter between two requesters.
// Each granted job optionally clears the counter, steps it N times, then reports code and overflow.
module gray_step_arbiter #(
  parameter int STEP_W = 4,
  parameter int CODE_W = 3
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              Req0,
  input  logic              Req1,
  input  logic [STEP_W-1:0] Steps0,
  input  logic [STEP_W-1:0] Steps1,
  input  logic              Clr0,
  input  logic              Clr1,
  output logic              Gnt0,
  output logic              Gnt1,
  output logic              Done0,
  output logic              Done1,
  output logic [CODE_W-1:0] Result,
  output logic              Ovf,
  output logic              Busy,
  output logic              Cnt_Reset,
  output logic              Cnt_En,
  input  logic [CODE_W-1:0] Cnt_Value,
  input  logic              Cnt_Overflow
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_RUN   = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [STEP_W-1:0]   remain_q, remain_d;
  logic                id_q, id_d;
  logic                last_q, last_d;
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                done0_q, done0_d;
  logic                done1_q, done1_d;
  logic [CODE_W-1:0]   result_q, result_d;
  logic                ovf_q, ovf_d;
  logic                busy_q;
  logic                cnt_reset_q;
  logic                cnt_en_q;

  logic                elig0_s, elig1_s;
  logic                pick_s;
  logic [STEP_W-1:0]   steps_sel_s;
  logic                clr_sel_s;

  // A requester whose Done pulse is showing is not eligible, so it cannot be re-granted back to back.
  assign elig0_s = Req0 & ~done0_q;
  assign elig1_s = Req1 & ~done1_q;

  // Next-state logic: arbitration, step countdown and result capture.
  always_comb begin
    state_d     = state_q;
    remain_d    = remain_q;
    id_d        = id_q;
    last_d      = last_q;
    gnt0_d      = gnt0_q;
    gnt1_d      = gnt1_q;
    done0_d     = 1'b0;
    done1_d     = 1'b0;
    result_d    = result_q;
    ovf_d       = ovf_q;

    if (elig0_s && elig1_s) begin
      pick_s = ~last_q;
    end else if (elig1_s) begin
      pick_s = 1'b1;
    end else begin
      pick_s = 1'b0;
    end
    steps_sel_s = pick_s ? Steps1 : Steps0;
    clr_sel_s   = pick_s ? Clr1 : Clr0;

    case (state_q)
      ST_IDLE: begin
        if (elig0_s || elig1_s) begin
          id_d     = pick_s;
          last_d   = pick_s;
          remain_d = steps_sel_s;
          gnt0_d   = ~pick_s;
          gnt1_d   = pick_s;
          if (clr_sel_s) begin
            state_d = ST_CLEAR;
          end else if (steps_sel_s != '0) begin
            state_d = ST_RUN;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        if (remain_q != '0) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_DONE;
        end
      end
      ST_RUN: begin
        remain_d = remain_q - STEP_W'(1);
        // RUN is only entered with a non-zero count; <= guards against an impossible zero.
        if (remain_q <= STEP_W'(1)) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        result_d = Cnt_Value;
        ovf_d    = Cnt_Overflow;
        done0_d  = ~id_q;
        done1_d  = id_q;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        state_d  = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; counter controls are registered from the next state.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q     <= ST_IDLE;
      remain_q    <= '0;
      id_q        <= 1'b0;
      last_q      <= 1'b1;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      done0_q     <= 1'b0;
      done1_q     <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      busy_q      <= 1'b0;
      cnt_reset_q <= 1'b0;
      cnt_en_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      remain_q    <= remain_d;
      id_q        <= id_d;
      last_q      <= last_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      done0_q     <= done0_d;
      done1_q     <= done1_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      busy_q      <= (state_d != ST_IDLE);
      cnt_reset_q <= (state_d == ST_CLEAR);
      cnt_en_q    <= (state_d == ST_RUN);
    end
  end

  assign Gnt0      = gnt0_q;
  assign Gnt1      = gnt1_q;
  assign Done0     = done0_q;
  assign Done1     = done1_q;
  assign Result    = result_q;
  assign Ovf       = ovf_q;
  assign Busy      = busy_q;
  assign Cnt_Reset = cnt_reset_q;
  assign Cnt_En    = cnt_en_q;

endmodule
